// File: rtl/memory_stage_if.sv
// ============================================================================
// memory_stage_if : request/grant/response data-memory bus
// Revision 1.0
// ============================================================================
`default_nettype none

interface memory_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [3:0]        dmem_wstrb;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [XLEN-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage : load/store access stage with data alignment and extension
// Revision 1.0
// ============================================================================
`default_nettype none

module memory_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  wire logic              clk_i,
  input  wire logic              rst,
  input  wire logic              execute_vaild_i,
  input  wire logic              ED_mem_rd_i,
  input  wire logic              ED_mem_wr_i,
  input  wire logic [2:0]        ED_mem_op_i,
  input  wire logic [ADDR_W-1:0] ED_valE_i,
  input  wire logic [XLEN-1:0]   ED_store_data_i,
  input  wire logic              write_back_allow_in_i,
  memory_stage_if.master         dmem,
  output logic [XLEN-1:0]        M_valM_o,
  output logic                   M_mem_err_o,
  output logic                   memory_ready_o,
  output logic                   memory_allow_in_o
);

  localparam logic [2:0] c_OP_B  = 3'b000;
  localparam logic [2:0] c_OP_H  = 3'b001;
  localparam logic [2:0] c_OP_W  = 3'b010;
  localparam logic [2:0] c_OP_BU = 3'b100;
  localparam logic [2:0] c_OP_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_valm;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [3:0]        r_wstrb;
  logic [2:0]        r_op;
  logic [1:0]        r_lane;

  logic              w_mem_op;
  logic              w_op_ok;
  logic              w_aligned;
  logic              w_legal;
  logic              w_issue;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_wstrb;
  logic [XLEN-1:0]   w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_ext;

  // Legality of the access presented by the execute stage
  always_comb begin
    w_mem_op  = execute_vaild_i & (ED_mem_rd_i | ED_mem_wr_i);
    w_op_ok   = 1'b0;
    w_aligned = 1'b1;
    case (ED_mem_op_i)
      c_OP_B, c_OP_H, c_OP_W: w_op_ok = 1'b1;
      c_OP_BU, c_OP_HU:       w_op_ok = ED_mem_rd_i;
      default:                w_op_ok = 1'b0;
    endcase
    case (ED_mem_op_i[1:0])
      2'b01:   w_aligned = ~ED_valE_i[0];
      2'b10:   w_aligned = (ED_valE_i[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
    w_legal = w_mem_op & w_op_ok & w_aligned;
    w_issue = (r_state == S_IDLE) & w_legal;
  end

  // Store lane encoding; loads carry no strobes and no data
  always_comb begin
    w_addr  = {ED_valE_i[ADDR_W-1:2], 2'b00};
    w_wstrb = 4'b0000;
    w_wdata = '0;
    if (ED_mem_wr_i) begin
      case (ED_mem_op_i[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << ED_valE_i[1:0];
          w_wdata = {(XLEN/8){ED_store_data_i[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << ED_valE_i[1:0];
          w_wdata = {(XLEN/16){ED_store_data_i[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = ED_store_data_i;
        end
      endcase
    end
  end

  // Load alignment and extension from the captured lane and funct3
  always_comb begin
    w_byte = dmem.dmem_rdata[7:0];
    case (r_lane)
      2'd0:    w_byte = dmem.dmem_rdata[7:0];
      2'd1:    w_byte = dmem.dmem_rdata[15:8];
      2'd2:    w_byte = dmem.dmem_rdata[23:16];
      default: w_byte = dmem.dmem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (r_op)
      c_OP_B:  w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_OP_BU: w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
      c_OP_H:  w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
      c_OP_HU: w_load_ext = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_ext = dmem.dmem_rdata;
    endcase
  end

  // In IDLE the bus is driven straight from the execute outputs so a
  // request can be granted with no added latency; in REQ it is replayed
  // from the captured copy.
  always_comb begin
    dmem.dmem_req   = w_issue | (r_state == S_REQ);
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = '0;
    dmem.dmem_wdata = '0;
    dmem.dmem_wstrb = 4'b0000;
    if (w_issue) begin
      dmem.dmem_we    = ED_mem_wr_i;
      dmem.dmem_addr  = w_addr;
      dmem.dmem_wdata = w_wdata;
      dmem.dmem_wstrb = w_wstrb;
    end else if (r_state == S_REQ) begin
      dmem.dmem_we    = r_we;
      dmem.dmem_addr  = r_addr;
      dmem.dmem_wdata = r_wdata;
      dmem.dmem_wstrb = r_wstrb;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valm  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= 4'b0000;
      r_op    <= 3'b000;
      r_lane  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_legal) begin
            r_we    <= ED_mem_wr_i;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_op    <= ED_mem_op_i;
            r_lane  <= ED_valE_i[1:0];
            r_valm  <= '0;
            if (dmem.dmem_gnt) begin
              r_state <= ED_mem_wr_i ? S_DONE : S_WAIT;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem.dmem_gnt) begin
            r_state <= r_we ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_rvalid) begin
            r_valm  <= w_load_ext;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Clearing on consume keeps the result at zero for whatever
          // IDLE presents next (bubbles, errors).
          if (write_back_allow_in_i) begin
            r_valm  <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign M_valM_o          = r_valm;
  assign M_mem_err_o       = (r_state == S_IDLE) & w_mem_op & ~w_legal;
  assign memory_ready_o    = ((r_state == S_IDLE) & ~w_legal) | (r_state == S_DONE);
  assign memory_allow_in_o = memory_ready_o & write_back_allow_in_i;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// tb_memory_stage : scoreboard bench for memory_stage with a scripted bus slave
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_memory_stage;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        execute_vaild_i;
  logic        ED_mem_rd_i;
  logic        ED_mem_wr_i;
  logic [2:0]  ED_mem_op_i;
  logic [31:0] ED_valE_i;
  logic [31:0] ED_store_data_i;
  logic        write_back_allow_in_i;
  logic [31:0] M_valM_o;
  logic        M_mem_err_o;
  logic        memory_ready_o;
  logic        memory_allow_in_o;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [31:0] valm;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  memory_stage_if #(.XLEN(32), .ADDR_W(32)) bus ();

  memory_stage #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i                 (clk_i),
    .rst                   (rst),
    .execute_vaild_i       (execute_vaild_i),
    .ED_mem_rd_i           (ED_mem_rd_i),
    .ED_mem_wr_i           (ED_mem_wr_i),
    .ED_mem_op_i           (ED_mem_op_i),
    .ED_valE_i             (ED_valE_i),
    .ED_store_data_i       (ED_store_data_i),
    .write_back_allow_in_i (write_back_allow_in_i),
    .dmem                  (bus),
    .M_valM_o              (M_valM_o),
    .M_mem_err_o           (M_mem_err_o),
    .memory_ready_o        (memory_ready_o),
    .memory_allow_in_o     (memory_allow_in_o)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic op_legal(input logic wr, input logic [2:0] op, input logic [31:0] a);
    logic ok;
    if (wr) ok = (op == 3'd0) || (op == 3'd1) || (op == 3'd2);
    else    ok = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
    if ((op == 3'd1 || op == 3'd5) && a[0]) ok = 1'b0;
    if (op == 3'd2 && a[1:0] != 2'b00) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    case (op)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] strb_model(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd0) return 4'b0001 << a[1:0];
    if (op == 3'd1) return 4'b0011 << a[1:0];
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] op, input logic [31:0] d);
    if (op == 3'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (op == 3'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  // Called one delta after a rising edge with the stage in IDLE; returns the
  // same way after the result has been consumed.
  task automatic run_access(input logic vld, input logic rd, input logic wr,
                            input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdata,
                            input int gd, input int rvd, input int stall, input string tag);
    exp_t e;
    exp_t got;
    logic legal;
    logic req_exp;
    int   cyc;
    int   gcyc;
    int   stl;
    logic done;
    legal  = vld && (rd || wr) && op_legal(wr, op, a);
    e.err  = vld && (rd || wr) && !legal;
    e.valm = (legal && rd) ? load_model(op, a, rdata) : 32'd0;
    e.lat  = !legal ? stall : (wr ? gd + 1 + stall : gd + rvd + 2 + stall);
    sb.push_back(e);

    execute_vaild_i = vld;
    ED_mem_rd_i     = rd;
    ED_mem_wr_i     = wr;
    ED_mem_op_i     = op;
    ED_valE_i       = a;
    ED_store_data_i = wd;
    cyc  = 0;
    gcyc = -1;
    stl  = stall;
    done = 1'b0;
    while (!done) begin
      bus.dmem_gnt          = 1'b0;
      bus.dmem_rvalid       = 1'b0;
      bus.dmem_rdata        = $urandom;
      write_back_allow_in_i = (stl == 0);
      #1;
      req_exp = legal && (gcyc < 0);
      if (bus.dmem_req && gcyc < 0 && cyc >= gd) begin
        bus.dmem_gnt = 1'b1;
        gcyc = cyc;
      end
      if (rd && gcyc >= 0 && cyc == gcyc + 1 + rvd) begin
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
      end
      @(negedge clk_i);
      check_value({tag, "_req"}, {31'd0, bus.dmem_req}, {31'd0, req_exp});
      if (bus.dmem_req) begin
        check_value({tag, "_addr"}, bus.dmem_addr, {a[31:2], 2'b00});
        check_value({tag, "_we"}, {31'd0, bus.dmem_we}, {31'd0, wr});
        check_value({tag, "_wstrb"}, {28'd0, bus.dmem_wstrb}, wr ? {28'd0, strb_model(op, a)} : 32'd0);
        if (wr) check_value({tag, "_wdata"}, bus.dmem_wdata, wdata_model(op, wd));
      end
      if (memory_ready_o) begin
        check_value({tag, "_allow"}, {31'd0, memory_allow_in_o}, {31'd0, write_back_allow_in_i});
        check_value({tag, "_valm_held"}, M_valM_o, e.valm);
        if (write_back_allow_in_i) begin
          got = sb.pop_front();
          check_value({tag, "_valm"}, M_valM_o, got.valm);
          check_value({tag, "_err"}, {31'd0, M_mem_err_o}, {31'd0, got.err});
          check_value({tag, "_lat"}, cyc, got.lat);
          done = 1'b1;
        end else begin
          stl--;
        end
      end else begin
        check_value({tag, "_allow_busy"}, {31'd0, memory_allow_in_o}, 32'd0);
      end
      if (!done && cyc > 60) begin
        check_value({tag, "_timeout"}, 32'd1, 32'd0);
        void'(sb.pop_front());
        done = 1'b1;
      end
      @(posedge clk_i);
      #1;
      cyc++;
    end
    execute_vaild_i       = 1'b0;
    ED_mem_rd_i           = 1'b0;
    ED_mem_wr_i           = 1'b0;
    bus.dmem_gnt          = 1'b0;
    bus.dmem_rvalid       = 1'b0;
    write_back_allow_in_i = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                   = 1'b1;
    execute_vaild_i       = 1'b0;
    ED_mem_rd_i           = 1'b0;
    ED_mem_wr_i           = 1'b0;
    ED_mem_op_i           = 3'd0;
    ED_valE_i             = 32'd0;
    ED_store_data_i       = 32'd0;
    write_back_allow_in_i = 1'b1;
    bus.dmem_gnt          = 1'b0;
    bus.dmem_rvalid       = 1'b0;
    bus.dmem_rdata        = 32'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_value("rst_valm", M_valM_o, 32'd0);
    check_value("rst_err", {31'd0, M_mem_err_o}, 32'd0);
    check_value("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    check_value("rst_ready", {31'd0, memory_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst = 1'b0;

    run_access(1, 1, 0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0, 0, "lb");
    run_access(1, 1, 0, 3'd4, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0, 0, "lbu");
    run_access(1, 0, 1, 3'd1, 32'h0000_0102, 32'h1234_ABCD, 32'd0, 3, 0, 0, "sh");
    run_access(1, 1, 0, 3'd2, 32'h0000_0101, 32'd0, 32'd0, 0, 0, 0, "lw_mis");
    run_access(1, 1, 0, 3'd2, 32'h0000_0200, 32'd0, 32'hCAFE_F00D, 0, 0, 2, "lw_stall");
    run_access(1, 0, 0, 3'd0, 32'h0000_0000, 32'd0, 32'd0, 0, 0, 0, "nonmem");
    run_access(1, 1, 0, 3'd5, 32'h0000_0012, 32'd0, 32'h8765_4321, 1, 2, 0, "lhu");
    run_access(1, 1, 0, 3'd1, 32'h0000_0012, 32'd0, 32'h8765_4321, 0, 1, 0, "lh");
    run_access(1, 0, 1, 3'd0, 32'h0000_0041, 32'h0000_00A5, 32'd0, 0, 0, 1, "sb");
    run_access(1, 0, 1, 3'd2, 32'h0000_0040, 32'h0BAD_BEEF, 32'd0, 2, 0, 0, "sw");
    run_access(1, 0, 1, 3'd4, 32'h0000_0040, 32'h1111_1111, 32'd0, 0, 0, 0, "s_badop");
    run_access(1, 1, 0, 3'd1, 32'h0000_0033, 32'd0, 32'd0, 0, 0, 0, "lh_mis");
    run_access(0, 1, 0, 3'd2, 32'h0000_0040, 32'd0, 32'd0, 0, 0, 0, "bubble");

    for (int i = 0; i < 30; i++) begin
      int   kind;
      logic rd;
      logic wr;
      kind = $urandom_range(0, 9);
      rd   = (kind >= 1 && kind <= 5);
      wr   = (kind >= 6);
      run_access(1'b1, rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), "rnd");
    end

    // Reset while a load waits for data; the late rvalid must be dropped
    execute_vaild_i = 1'b1;
    ED_mem_rd_i     = 1'b1;
    ED_mem_op_i     = 3'd2;
    ED_valE_i       = 32'h0000_0300;
    #1;
    bus.dmem_gnt = 1'b1;
    @(posedge clk_i);
    #1;
    bus.dmem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk_i);
    check_value("rstw_busy", {31'd0, memory_ready_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst             = 1'b0;
    execute_vaild_i = 1'b0;
    ED_mem_rd_i     = 1'b0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check_value("rstw_ready", {31'd0, memory_ready_o}, 32'd1);
    check_value("rstw_req", {31'd0, bus.dmem_req}, 32'd0);
    @(posedge clk_i);
    #1;
    bus.dmem_rvalid = 1'b0;
    @(negedge clk_i);
    check_value("rstw_valm", M_valM_o, 32'd0);
    check_value("rstw_ready2", {31'd0, memory_ready_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_stage.md
# memory_stage

Data-memory access stage sitting between the execute register and `memory_reg`. It takes the load/store described by the execute-stage outputs, runs it on a request/grant/response data-memory bus, and aligns and extends load data into `M_valM_o`. It drives `memory_ready_o`, which `memory_reg` uses to capture the result or insert a bubble. It also drives `memory_allow_in_o`, which stalls the execute register.

## Interface
- `XLEN`, 32: data width; only 32 supported.
- `ADDR_W`, 32: byte-address width.
- `clk_i`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `execute_vaild_i`  in  1  ED_* holds a valid instruction.
- `ED_mem_rd_i`  in  1  instruction is a load.
- `ED_mem_wr_i`  in  1  instruction is a store; never both with rd.
- `ED_mem_op_i`  in  3  funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
- `ED_valE_i`  in  ADDR_W  effective byte address.
- `ED_store_data_i`  in  XLEN  rs2 value.
- `write_back_allow_in_i`  in  1  downstream accepts this cycle.
- `dmem_req_o`  out  1  bus request.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  ADDR_W  word address, {ED_valE_i[ADDR_W-1:2], 2'b00}.
- `dmem_wdata_o`  out  XLEN  lane-replicated store data.
- `dmem_wstrb_o`  out  4  byte enables; 0 for loads.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  read data valid; one cycle or more after grant.
- `dmem_rdata_i`  in  XLEN  read word.
- `M_valM_o`  out  XLEN  extended load result.
- `M_mem_err_o`  out  1  misaligned access or illegal funct3.
- `memory_ready_o`  out  1  the stage's result is valid this cycle.
- `memory_allow_in_o`  out  1  equals `memory_ready_o & write_back_allow_in_i`.

## Operation
- States:
  - IDLE: no access in flight.
  - REQ: request issued, awaiting grant.
  - WAIT: load granted, awaiting data.
  - DONE: result held until consumed.
- Legal access: `execute_vaild_i & (ED_mem_rd_i | ED_mem_wr_i)`, a valid funct3, and natural alignment:
  - halfword: addr[0] = 0;
  - word: addr[1:0] = 0.
- IDLE:
  - On a legal access, `dmem_req_o` is asserted combinationally. With gnt, go to WAIT (load) or DONE (store); without gnt, go to REQ.
  - Otherwise, `memory_ready_o` = 1, which covers non-memory instructions, bubbles, and errors.
  - For a memory op that is misaligned or has an illegal funct3: `M_mem_err_o` = 1, `M_valM_o` = 0, no bus request.
- REQ: `dmem_req_o` held high with address, data and strobes stable. On gnt, go to WAIT (load) or DONE (store).
- WAIT: on rvalid, register the extended data into `M_valM_o` and go to DONE.
- DONE: `memory_ready_o` = 1. If `write_back_allow_in_i`, go to IDLE; otherwise hold with `M_valM_o` stable.
- Load extension uses lane = addr[1:0]:
  - LB/LBU: sign/zero-extend byte[lane].
  - LH/LHU: sign/zero-extend half[addr[1]].
  - LW: the whole word.
- Store encoding:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0], wdata = {2{data[15:0]}}.
  - SW: wstrb = 1111, wdata = data.
- Stores leave `M_valM_o` = 0.
- `execute_vaild_i` and ED_* are sampled only in IDLE. A granted access always completes; ED_* stays stable because `memory_allow_in_o` = 0 until consume.
- In IDLE and REQ, `dmem_rvalid_i` is ignored.

## Timing
- Reset values: state IDLE, `M_valM_o` 0, `M_mem_err_o` 0, `dmem_req_o` 0. `memory_ready_o` = 1 when `execute_vaild_i` is 0.
- With immediate grant and rvalid one cycle later, a load is consumed at the end of cycle 2 (cycle 0 = request).
- With immediate grant, a store is ready in cycle 1.
- A non-memory instruction is ready in cycle 0, with zero added latency.
- Every extra grant or rvalid wait cycle adds one cycle.
- A new access cannot start in the cycle a DONE result is consumed. It starts in IDLE the next cycle.
- `rst` mid-access: return to IDLE next edge and clear the outputs. A late `dmem_rvalid_i` is then dropped.

## Test plan
- LB at addr 0x103, rdata 0x80FF_0000, gnt at cycle 0, rvalid at cycle 1 -> `M_valM_o` = 0xFFFF_FF80, ready in cycle 2; LBU gives 0x0000_0080.
- SH at 0x102, data 0x1234_ABCD, gnt delayed 3 cycles -> req held 4 cycles, wstrb = 1100, wdata = 0xABCD_ABCD, ready 1 cycle after gnt.
- LW at 0x101 -> no `dmem_req_o`, `M_mem_err_o` = 1, `memory_ready_o` = 1 in the same cycle.
- Load completes while `write_back_allow_in_i` = 0 for 2 cycles -> DONE held, `M_valM_o` stable, `memory_allow_in_o` = 0; consumed on the 3rd cycle.
- Non-memory instruction with `execute_vaild_i` = 1 -> ready in the same cycle, `dmem_req_o` = 0.
- Reset asserted in WAIT, rvalid arrives after reset -> IDLE, `M_valM_o` stays 0.
